// File: rtl/sirv_gnrl_skid_stage.sv
// Two-entry valid/ready skid stage with registered upstream ready.
// Optional same-cycle EMPTY-state pass-through when SIRV_SKID_BYPASS_EN is defined.
module sirv_gnrl_skid_stage #(
   parameter int unsigned DW = 32
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          flush,
   input  logic          i_vld,
   output logic          i_rdy,
   input  logic [DW-1:0] i_dat,
   output logic          o_vld,
   input  logic          o_rdy,
   output logic [DW-1:0] o_dat,
   output logic [1:0]    occ
);

   typedef enum logic [1:0] {
      EMPTY = 2'd0,
      ONE   = 2'd1,
      TWO   = 2'd2
   } state_t;

   state_t        state_q, state_d;
   logic [DW-1:0] main_q, skid_q, main_d;
   logic          rdy_q, vld_q;
   logic          main_le, skid_le;
   logic          in_hs, out_hs;

   assign in_hs  = i_vld & rdy_q;
   assign out_hs = o_vld & o_rdy;

`ifdef SIRV_SKID_BYPASS_EN
   // In EMPTY the input word is presented straight to the output.
   assign o_vld = (state_q == EMPTY) ? i_vld : vld_q;
   assign o_dat = (state_q == EMPTY) ? i_dat : main_q;
`else
   assign o_vld = vld_q;
   assign o_dat = main_q;
`endif

   assign i_rdy = rdy_q;
   assign occ   = state_q;

   // Next state and entry load enables; flush overrides every handshake.
   always_comb begin
      state_d = state_q;
      main_le = 1'b0;
      skid_le = 1'b0;
      main_d  = i_dat;
      case (state_q)
         EMPTY: begin
`ifdef SIRV_SKID_BYPASS_EN
            if (in_hs && !o_rdy) begin
`else
            if (in_hs) begin
`endif
               main_le = 1'b1;
               state_d = ONE;
            end
         end
         ONE: begin
            if (in_hs && out_hs) begin
               main_le = 1'b1;
            end else if (in_hs) begin
               skid_le = 1'b1;
               state_d = TWO;
            end else if (out_hs) begin
               state_d = EMPTY;
            end
         end
         TWO: begin
            if (out_hs) begin
               main_le = 1'b1;
               main_d  = skid_q;
               state_d = ONE;
            end
         end
         default: state_d = EMPTY;
      endcase
      if (flush) begin
         state_d = EMPTY;
         main_le = 1'b0;
         skid_le = 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= EMPTY;
         rdy_q   <= 1'b1;
         vld_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         rdy_q   <= (state_d != TWO);
         vld_q   <= (state_d != EMPTY);
      end
   end

   // Payload entries change only under their own load enables.
   always_ff @(posedge clk) begin
      if (rst) begin
         main_q <= '0;
         skid_q <= '0;
      end else begin
         if (main_le) main_q <= main_d;
         if (skid_le) skid_q <= i_dat;
      end
   end

`ifndef SYNTHESIS
   // Upstream must hold a stalled word until it is accepted.
   a_hold_stall: assert property (@(posedge clk) disable iff (rst)
      (i_vld && !i_rdy) |=> (i_vld && $stable(i_dat)));
`endif

endmodule
